mpy_seq_n: RTL and testbench

//  Parametrised multi-cycle integer multiplier for the datapath MULT/MULTU path.

---
 rtl/mpy_seq_n_if.sv | 24 ++
 rtl/mpy_seq_n.sv | 120 ++++++++++++
 tb/tb_mpy_seq_n.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mpy_seq_n_if.sv
// Handshake and operand/result bundle for the sequential multiplier.
// slave = multiplier side, master = requester side.
interface mpy_seq_n_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y_hi;
  logic [WIDTH-1:0] y_lo;

  modport master (
    output start, signed_op, a, b,
    input  busy, done, y_hi, y_lo
  );

  modport slave (
    input  start, signed_op, a, b,
    output busy, done, y_hi, y_lo
  );
endinterface

// File: rtl/mpy_seq_n.sv
// Iterative shift-add multiplier (one multiplier bit per cycle), signed or unsigned.
// Optional MPY_EARLY_TERM_EN: leave CALC as soon as the remaining multiplier bits are zero.
module mpy_seq_n #(
  parameter int unsigned WIDTH = 32
) (
  input logic         clk,
  input logic         reset,
  mpy_seq_n_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   y_hi_q, y_hi_d;
  logic [WIDTH-1:0]   y_lo_q, y_lo_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic               calc_last;

  // Magnitude of the most-negative operand is 2^(W-1), which still fits unsigned.
  always_comb begin
    a_mag = (bus.signed_op && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
    b_mag = (bus.signed_op && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;
    prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    y_hi_d    = y_hi_q;
    y_lo_d    = y_lo_q;
    calc_last = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start && !busy_q) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          neg_d    = bus.signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = CntW'(WIDTH);
          busy_d   = 1'b1;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
`ifdef MPY_EARLY_TERM_EN
        calc_last = (cnt_q == CntW'(1)) || (mplier_d == '0);
`else
        calc_last = (cnt_q == CntW'(1));
`endif
        if (calc_last) begin
          state_d = StFix;
        end
      end
      StFix: begin
        y_hi_d  = prod_fix[2*WIDTH-1:WIDTH];
        y_lo_d  = prod_fix[WIDTH-1:0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      y_hi_q   <= '0;
      y_lo_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      y_hi_q   <= y_hi_d;
      y_lo_q   <= y_lo_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.y_hi = y_hi_q;
  assign bus.y_lo = y_lo_q;

endmodule

// File: tb/tb_mpy_seq_n.sv
// Directed bench for mpy_seq_n (WIDTH=32): vector table plus busy/done/reset sequences.
module tb_mpy_seq_n;

  localparam int unsigned W = 32;
  localparam int MaxWait = 100;

  logic clk = 1'b0;
  logic reset = 1'b1;

  mpy_seq_n_if #(.WIDTH(W)) bus ();

  mpy_seq_n #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          s;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [63:0]   p;
    int            lat_e;  // done latency with early termination
  } vec_t;

  vec_t vecs[12];
  int checks = 0;
  int errors = 0;

  function automatic int exp_lat(input int lat_e);
`ifdef MPY_EARLY_TERM_EN
    return lat_e;
`else
    return W + 1;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive a request; returns #1 after the accepting edge with start dropped.
  task automatic start_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.signed_op = s;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts edges after the current one until done is seen; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= MaxWait; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  int lat;
  logic [63:0] prev;

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 3};
    vecs[1]  = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33};
    vecs[2]  = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 2};
    vecs[3]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33};
    vecs[4]  = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE, 3};
    vecs[5]  = '{1'b0, 32'h0000_0005, 32'h0000_0003, 64'h0000_0000_0000_000F, 3};
    vecs[6]  = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFB, 64'h0000_0000_0000_0000, 4};
    vecs[7]  = '{1'b0, 32'h1234_5678, 32'h0000_0000, 64'h0000_0000_0000_0000, 2};
    vecs[8]  = '{1'b0, 32'h0000_0003, 32'h8000_0000, 64'h0000_0001_8000_0000, 33};
    vecs[9]  = '{1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA, 3};
    vecs[10] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000, 2};
    vecs[11] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33};

    bus.start = 1'b0;
    bus.signed_op = 1'b0;
    bus.a = '0;
    bus.b = '0;

    #1;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_y", {bus.y_hi, bus.y_lo}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_no_done", 64'(bus.done), 64'd0);

    for (int v = 0; v < 12; v++) begin
      start_op(vecs[v].s, vecs[v].a, vecs[v].b);
      check($sformatf("v%0d_busy", v), 64'(bus.busy), 64'd1);
      wait_done(lat);
      check($sformatf("v%0d_lat", v), 64'(lat), 64'(exp_lat(vecs[v].lat_e)));
      check($sformatf("v%0d_prod", v), {bus.y_hi, bus.y_lo}, vecs[v].p);
      check($sformatf("v%0d_busy_at_done", v), 64'(bus.busy), 64'd0);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_pulse", v), 64'(bus.done), 64'd0);
      check($sformatf("v%0d_hold", v), {bus.y_hi, bus.y_lo}, vecs[v].p);
    end

    // start while busy is ignored; operands are not resampled
    start_op(1'b0, 32'h0000_0007, 32'h8000_0001);
    start_op(1'b0, 32'h0000_0001, 32'h0000_0001);
    wait_done(lat);
    check("busy_start_lat", 64'(lat >= 0 ? lat + 1 : lat), 64'(exp_lat(33)));
    check("busy_start_prod", {bus.y_hi, bus.y_lo}, 64'h0000_0003_8000_0007);

    // start while done is high is accepted; old result held until next FIX
    prev = {bus.y_hi, bus.y_lo};
    bus.start = 1'b1;
    bus.signed_op = 1'b0;
    bus.a = 32'h0000_0002;
    bus.b = 32'h4000_0000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("b2b_busy", 64'(bus.busy), 64'd1);
    check("b2b_hold_old", {bus.y_hi, bus.y_lo}, prev);
    wait_done(lat);
    check("b2b_lat", 64'(lat), 64'(exp_lat(32)));
    check("b2b_prod", {bus.y_hi, bus.y_lo}, 64'h0000_0000_8000_0000);

    // asynchronous reset mid-CALC aborts the operation
    start_op(1'b1, 32'h0000_0007, 32'h8000_0000);
    repeat (9) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_y", {bus.y_hi, bus.y_lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_done(lat);
    check("abort_no_done", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
    check("abort_y_after", {bus.y_hi, bus.y_lo}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
